// File: rtl/ffd_synchro_filter.sv
// Per-bit synchroniser chain followed by a glitch filter that needs FILTER_LEN
// consecutive mismatching samples before the output level follows.
`timescale 1ns/1ps

module ffd_synchro_filter #(
  parameter int               WIDTH       = 1,
  parameter int               STAGES      = 2,
  parameter int               FILTER_LEN  = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             aclk,
  input  logic             arst,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  generate
    if (STAGES < 2) begin : g_bad_stages
      $error("ffd_synchro_filter: STAGES must be >= 2");
    end
    if (FILTER_LEN < 1) begin : g_bad_filter
      $error("ffd_synchro_filter: FILTER_LEN must be >= 1");
    end
  endgenerate

  logic [WIDTH-1:0] r_stage [STAGES];
  logic [WIDTH-1:0] w_sync;
  logic [CW-1:0]    r_cnt   [WIDTH];
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      for (int s = 0; s < STAGES; s++) r_stage[s] <= RESET_VALUE;
    end else begin
      r_stage[0] <= data_i;
      for (int s = 1; s < STAGES; s++) r_stage[s] <= r_stage[s-1];
    end
  end

  assign w_sync = r_stage[STAGES-1];

  // A return to the held level clears the count, so only an unbroken run
  // of FILTER_LEN mismatching samples moves the output.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      r_data <= RESET_VALUE;
      r_rise <= '0;
      r_fall <= '0;
      for (int b = 0; b < WIDTH; b++) r_cnt[b] <= '0;
    end else begin
      r_rise <= '0;
      r_fall <= '0;
      for (int b = 0; b < WIDTH; b++) begin
        if (w_sync[b] == r_data[b]) begin
          r_cnt[b] <= '0;
        end else if (r_cnt[b] == CNT_LAST) begin
          r_data[b] <= w_sync[b];
          r_cnt[b]  <= '0;
          r_rise[b] <= w_sync[b];
          r_fall[b] <= ~w_sync[b];
        end else begin
          r_cnt[b] <= r_cnt[b] + CW'(1);
        end
      end
    end
  end

  assign data_o = r_data;
  assign rise_o = r_rise;
  assign fall_o = r_fall;

endmodule
